// File: rtl/aes_pkg.sv
// Shared types and constants for the AES core arbiter.
package aes_pkg;

  typedef logic [127:0] block_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    RESP,
    DRAIN
  } arb_state_t;

  localparam int unsigned NREQ = 2;

endpackage

// File: rtl/aes_rr_pick.sv
// Round-robin winner selection between the two requesters. Purely combinational:
// a lone requester always wins; on a tie the one not served last wins.
module aes_rr_pick
  import aes_pkg::*;
(
  input  logic [NREQ-1:0] req_valid,
  input  logic            last,
  output logic [NREQ-1:0] grant
);

  // One-hot grant from the pending set and the most recently served index.
  always_comb begin
    grant = '0;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

endmodule

// File: rtl/aes_arbiter.sv
// Shares one aes_core between two requesters. A job is accepted round-robin,
// its operands are latched, the core is loaded and polled for done, and the
// result (or a timeout error) is returned to the requester that was granted.
// The core itself sits outside this block and connects through the core_* ports.
module aes_arbiter
  import aes_pkg::*;
#(
  parameter int unsigned LOAD_CYCLES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [1:0][127:0] req_key,
  input  logic [1:0][127:0] req_plaintext,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [127:0]      rsp_cyphertext,
  output logic              rsp_error,
  output logic              core_load,
  output logic [127:0]      core_key,
  output logic [127:0]      core_plaintext,
  input  logic              core_done,
  input  logic [127:0]      core_cyphertext
);

  localparam int unsigned LW = (LOAD_CYCLES < 2) ? 1 : $clog2(LOAD_CYCLES + 1);
  localparam int unsigned TW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [LW-1:0] LOAD_END = LW'(LOAD_CYCLES);
  localparam logic [TW-1:0] TIME_END = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIME_SAT = '1;

  arb_state_t     state_q;
  logic           last_q;
  logic           win_q;
  logic [LW-1:0]  lcnt_q;
  logic [TW-1:0]  tcnt_q;
  logic [1:0]     grant;
  logic           win_now;

  aes_rr_pick u_pick (
    .req_valid (req_valid),
    .last      (last_q),
    .grant     (grant)
  );

  assign win_now = grant[1];

  // Job FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      last_q         <= 1'b1;
      win_q          <= 1'b0;
      lcnt_q         <= '0;
      tcnt_q         <= '0;
      req_ready      <= '0;
      rsp_valid      <= '0;
      rsp_cyphertext <= '0;
      rsp_error      <= 1'b0;
      core_load      <= 1'b0;
      core_key       <= '0;
      core_plaintext <= '0;
    end else begin
      req_ready <= '0;
      case (state_q)
        IDLE: begin
          if (|req_valid) begin
            req_ready      <= grant;
            win_q          <= win_now;
            last_q         <= win_now;
            // Operands are owned by the arbiter from here on.
            core_key       <= req_key[win_now];
            core_plaintext <= req_plaintext[win_now];
            lcnt_q         <= '0;
            state_q        <= LOAD;
          end
        end
        LOAD: begin
          if (lcnt_q == LOAD_END) begin
            core_load <= 1'b0;
            tcnt_q    <= '0;
            state_q   <= RUN;
          end else begin
            core_load <= 1'b1;
            lcnt_q    <= lcnt_q + 1'b1;
          end
        end
        RUN: begin
          // tcnt_q == 0 marks the first RUN cycle, where done may be stale.
          if (tcnt_q != '0 && core_done) begin
            rsp_valid      <= {win_q, ~win_q};
            rsp_cyphertext <= core_cyphertext;
            rsp_error      <= 1'b0;
            state_q        <= RESP;
          end else if (TIMEOUT_CYCLES != 0 && tcnt_q == TIME_END) begin
            rsp_valid      <= {win_q, ~win_q};
            rsp_cyphertext <= '0;
            rsp_error      <= 1'b1;
            state_q        <= RESP;
          end else if (tcnt_q != TIME_SAT) begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready[win_q]) begin
            rsp_valid      <= '0;
            rsp_cyphertext <= '0;
            rsp_error      <= 1'b0;
            state_q        <= DRAIN;
          end
        end
        DRAIN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/aes_arbiter.md
# aes_arbiter

- Shares one `aes_core` between two requesters, for example an SPI-loaded host path and an on-chip self-test source.
- Accepts a key/plaintext pair from a requester and picks between requesters round-robin.
- Drives the core's `load` pulse, waits for `done`, and returns the ciphertext to the requester that was granted.
- Sits directly between the requesters and `aes_core`; the core is used unmodified.

## Interface
- `LOAD_CYCLES`, default 2: number of cycles `core_load` is held high; minimum 1.
- `TIMEOUT_CYCLES`, default 64: cycles to wait for `core_done` after `core_load` falls before abandoning the job; 0 disables the timeout.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `req_valid` input [1:0]: requester i has a job pending.
- `req_ready` output [1:0]: one-hot; job from i accepted this cycle.
- `req_key` input [1:0][127:0]: per-requester key.
- `req_plaintext` input [1:0][127:0]: per-requester plaintext.
- `rsp_valid` output [1:0]: one-hot; result for i is available.
- `rsp_ready` input [1:0]: requester i consumes the result.
- `rsp_cyphertext` output 128: result data, shared by both requesters.
- `rsp_error` output 1: qualifies `rsp_valid`; 1 means the job timed out.
- `core_load` output 1: connects to `aes_core` `load`.
- `core_key` output 128: connects to `aes_core` `key`.
- `core_plaintext` output 128: connects to `aes_core` `plaintext`.
- `core_done` input 1: from `aes_core`; treated as a level.
- `core_cyphertext` input 128: from `aes_core`.

## Operation
- The FSM has five states: IDLE, LOAD, RUN, RESP, DRAIN.
- **IDLE**
  - If any `req_valid` bit is set, pick winner w, pulse `req_ready[w]` for one cycle, and latch w plus its key and plaintext into internal registers.
  - Go to LOAD.
- **LOAD**
  - `core_load` = 1, with `core_key`/`core_plaintext` driven from the latched registers.
  - Hold for exactly `LOAD_CYCLES` cycles, then go to RUN.
- **RUN**
  - `core_load` = 0; the latched operands stay on the core inputs.
  - `core_done` is ignored on the first RUN cycle, because `done` may still be stale from the previous job.
  - From the second RUN cycle on, `core_done` = 1 latches `core_cyphertext`, sets error = 0, and goes to RESP.
  - If the timeout counter reaches `TIMEOUT_CYCLES` first: ciphertext = 0, error = 1, go to RESP.
- **RESP**
  - `rsp_valid[w]` = 1, with `rsp_cyphertext` and `rsp_error` held stable.
  - On `rsp_ready[w]` = 1, go to DRAIN.
  - `rsp_ready` on the other bit is ignored.
- **DRAIN**
  - Lasts one cycle with all outputs inactive, then returns to IDLE.
  - This guarantees a gap of at least one cycle between jobs.
- **Winner selection**
  - A `last` register records the most recently served requester; it resets to 1, so requester 0 wins the first tie.
  - If only one `req_valid` bit is set, that requester wins.
  - If both are set, the requester not equal to `last` wins.
  - `last` updates to w at the moment of acceptance.
- **Input ownership:** requesters may change their inputs or drop `req_valid` at any time before acceptance. After acceptance, only the latched copy is used.
- **Reset values** (also applied on reset mid-job): state = IDLE, `last` = 1, and all outputs 0, including `req_ready`, `rsp_valid`, `rsp_cyphertext`, `rsp_error`, `core_load`, `core_key`, `core_plaintext`. The in-flight job is discarded and the core is simply reloaded by the next job.

## Timing
- Accept to first `core_load` high: 1 cycle.
- `core_load` high: `LOAD_CYCLES` cycles.
- `core_done` high to `rsp_valid`: 1 cycle (registered).
- `rsp_ready` to the next `req_ready`: 2 cycles minimum (DRAIN, then IDLE).
- Overall latency from acceptance to `rsp_valid` is 1 + `LOAD_CYCLES` + core latency + 1 cycles.
- Timeout counter:
  - Counts RUN cycles, starting at 0 on entry to RUN.
  - Width is $clog2(`TIMEOUT_CYCLES`+1).
  - Saturates, so it never wraps.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- `aes_pkg` holds:
  - `typedef logic [127:0] block_t`
  - `typedef enum logic [2:0] {IDLE, LOAD, RUN, RESP, DRAIN} arb_state_t`
  - `localparam NREQ = 2`
- Sub-module `aes_rr_pick`: purely combinational; takes `req_valid[1:0]` and `last`, returns the one-hot grant. It is tested by the same bench.
- The FSM, operand/result registers and counters live in `aes_arbiter`.
- The top level instantiates `aes_arbiter` plus one `aes_core`.

## Test plan
1. **Single request.** Requester 0 submits key 2B7E151628AED2A6ABF7158809CF4F3C, plaintext 3243F6A8885A308D313198A2E0370734.
   - Expect `rsp_valid` = 01 with 3925841D02DC09FBDC118597196A0B32 and `rsp_error` = 0.
   - Expect `core_load` high for exactly 2 cycles.
2. **Simultaneous requests after reset.** Requester 1 uses key 000102030405060708090A0B0C0D0E0F, plaintext 00112233445566778899AABBCCDDEEFF.
   - Requester 0 is served first (FIPS result as in scenario 1).
   - Requester 1 is served second with 69C4E0D86A7B0430D8CDB78070B4C55A.
3. **Round-robin.** Both requesters hold `req_valid` for 4 jobs.
   - Grants alternate 0, 1, 0, 1.
   - Every result matches its own requester's vector.
4. **Response backpressure.** Hold `rsp_ready` = 0 for 20 cycles.
   - `rsp_valid` and `rsp_cyphertext` stay stable.
   - No `req_ready` is issued until 2 cycles after `rsp_ready` rises.
5. **Timeout.** Stub the core so `core_done` is held at 0, with `TIMEOUT_CYCLES` = 8.
   - `rsp_valid` rises with `rsp_error` = 1 and `rsp_cyphertext` = 0 exactly 9 cycles after `core_load` falls.
6. **Reset mid-job.** Assert `reset` during RUN.
   - All outputs are 0 immediately.
   - The next request completes with the correct ciphertext, and requester 0 wins the first tie.
